// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Magnitude of a w-bit two's-complement value carried in the low bits of v.
  // The most-negative value maps to its unsigned magnitude 2^(w-1).
  function automatic logic [31:0] abs_w(input logic [31:0] v, input int w);
    logic [63:0] mask;
    logic [31:0] neg;
    mask = (64'd1 << w) - 64'd1;
    neg  = ~v + 32'd1;
    if (v[w-1]) abs_w = neg & mask[31:0];
    else        abs_w = v & mask[31:0];
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: operand magnitudes, accumulator, one WIDTH-bit adder, final sign fix-up.
// prod is registered on the last iteration and otherwise held.
module seq_mult_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] prod
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   xmag;
  logic [WIDTH-1:0]   ymag;
  logic               neg;

  always_comb begin
    xmag = X;
    ymag = Y;
    if (signed_mode == MODE_SIGNED) begin
      xmag = WIDTH'(abs_w(32'(X), WIDTH));
      ymag = WIDTH'(abs_w(32'(Y), WIDTH));
    end
  end

  // Upper half plus multiplicand keeps its carry, which shifts into the top bit.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      prod  <= '0;
    end else if (load) begin
      mcand <= xmag;
      acc   <= {{WIDTH{1'b0}}, ymag};
      neg   <= (signed_mode == MODE_SIGNED) && (X[WIDTH-1] ^ Y[WIDTH-1]);
    end else if (step) begin
      acc <= acc_nxt;
      if (last) prod <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// WIDTH x WIDTH sequential multiplier with valid/ready on both sides.
// Result appears WIDTH+1 edges after acceptance (counting the accepting edge) and is held until taken.
module seq_mult
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .last       (last),
    .X          (X),
    .Y          (Y),
    .signed_mode(signed_mode),
    .prod       (out)
  );

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: an 8-bit and a 16-bit instance checked against a cycle-level arithmetic model.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[2];
  logic        ordy[2];
  logic        sm[2];
  logic [15:0] xi[2];
  logic [15:0] yi[2];
  logic        ir0, ov0, bz0, ir1, ov1, bz1;
  logic [15:0] o0;
  logic [31:0] o1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wd[2]    = '{8, 16};

  // model: phase 0 = idle, 1 = computing, 2 = holding result
  int          ph[2];
  int          rem[2];
  logic [31:0] pend[2];
  logic [31:0] mout[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
    .X(xi[0][7:0]), .Y(yi[0][7:0]), .signed_mode(sm[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out(o0), .busy(bz0)
  );

  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
    .X(xi[1]), .Y(yi[1]), .signed_mode(sm[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out(o1), .busy(bz1)
  );

  // {in_ready, out_valid, busy, out zero-extended to 32 bits}
  function automatic logic [34:0] obs(input int k);
    if (k == 0) return {ir0, ov0, bz0, 16'h0, o0};
    return {ir1, ov1, bz1, o1};
  endfunction

  function automatic logic [31:0] golden(input logic [15:0] x, input logic [15:0] y,
                                         input logic s, input int w);
    longint a, b, p;
    a = longint'(x) & ((longint'(1) << w) - 1);
    b = longint'(y) & ((longint'(1) << w) - 1);
    if (s && a[w-1]) a = a - (longint'(1) << w);
    if (s && b[w-1]) b = b - (longint'(1) << w);
    p = a * b;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Compare on the falling edge, then advance the model by what the next rising edge does.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        ph[k]   = 0;
        rem[k]  = 0;
        mout[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [34:0] req, got;
        req = {ph[k] == 0, ph[k] == 2, ph[k] != 0, mout[k]};
        got = obs(k);
        checks++;
        if (got !== req) begin
          failures++;
          $display("FAIL model_cmp[%0d]: got %h required %h (t=%0t)", k, got, req, $time);
        end
        case (ph[k])
          0: if (iv[k]) begin
               ph[k]   = 1;
               rem[k]  = wd[k];
               pend[k] = golden(xi[k], yi[k], sm[k], wd[k]);
             end
          1: begin
               rem[k]--;
               if (rem[k] == 0) begin
                 ph[k]   = 2;
                 mout[k] = pend[k];
               end
             end
          default: if (ordy[k]) ph[k] = 0;
        endcase
      end
    end
  end

  task automatic wait_accept(input int k, output bit ok);
    logic [34:0] o;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      o = obs(k);
      if (o[34]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // One operation; bp>0 withholds out_ready for bp cycles once the result is valid.
  task automatic op(input int k, input logic [15:0] x, input logic [15:0] y, input logic s,
                    input int bp, output logic [31:0] res, output int lat);
    logic [34:0] o;
    bit ok;
    xi[k] = x; yi[k] = y; sm[k] = s; iv[k] = 1'b1; ordy[k] = (bp == 0);
    wait_accept(k, ok);
    #1 iv[k] = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      o = obs(k);
      if (o[33]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!ok) chk("result_timeout", 32'd0, 32'd1);
    res = o[31:0];
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1 o = obs(k);
      chk("bp_valid_held", {31'd0, o[33]}, 32'd1);
      chk("bp_inready_low", {31'd0, o[34]}, 32'd0);
      chk("bp_out_held", o[31:0], res);
      ordy[k] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // in_valid held high, out_ready high: accept spacing must be WIDTH+2 cycles.
  task automatic stream(input int k, input int n, input logic s);
    int  prev;
    bit  ok;
    logic [34:0] o;
    prev = -1;
    ordy[k] = 1'b1; sm[k] = s; iv[k] = 1'b1;
    xi[k] = 16'($urandom); yi[k] = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        o = obs(k);
        if (o[34]) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("stream_timeout", 32'd0, 32'd1);
      if (prev >= 0) chk("stream_period", 32'(cyc - prev), 32'(wd[k] + 2));
      prev = cyc;
      @(posedge clk);
      #1 xi[k] = 16'($urandom); yi[k] = 16'($urandom);
    end
    iv[k] = 1'b0;
    repeat (wd[k] + 3) @(posedge clk);
    #1;
  endtask

  typedef struct { logic [15:0] x; logic [15:0] y; logic s; logic [31:0] p; } vec_t;
  vec_t v8[7] = '{
    '{16'hFF, 16'hFF, 1'b0, 32'hFE01},
    '{16'h00, 16'hC8, 1'b0, 32'h0000},
    '{16'h80, 16'h80, 1'b1, 32'h4000},
    '{16'hFF, 16'h01, 1'b1, 32'hFFFF},
    '{16'h80, 16'h7F, 1'b1, 32'hC080},
    '{16'hFF, 16'h00, 1'b1, 32'h0000},
    '{16'hF6, 16'h07, 1'b1, 32'hFFBA}
  };
  logic [15:0] c16[5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};

  initial begin
    logic [31:0] res;
    logic [34:0] o;
    int lat;
    bit ok;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; sm[k] = 1'b0; xi[k] = '0; yi[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 o = obs(0);
    chk("reset_in_ready", {31'd0, o[34]}, 32'd1);
    chk("reset_out_valid", {31'd0, o[33]}, 32'd0);
    chk("reset_busy", {31'd0, o[32]}, 32'd0);
    chk("reset_out", o[31:0], 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (v8[i]) begin
      op(0, v8[i].x, v8[i].y, v8[i].s, 0, res, lat);
      chk($sformatf("dir8_%0d", i), res, v8[i].p);
      chk($sformatf("lat8_%0d", i), 32'(lat), 32'd9);
    end

    op(0, 16'd12, 16'd13, 1'b0, 20, res, lat);
    chk("bp_product", res, 32'd156);
    o = obs(0);
    chk("bp_release_in_ready", {31'd0, o[34]}, 32'd1);
    chk("bp_release_out_valid", {31'd0, o[33]}, 32'd0);
    chk("bp_out_retained", o[31:0], 32'd156);

    xi[0] = 16'd9; yi[0] = 16'd11; sm[0] = 1'b0; iv[0] = 1'b1;
    wait_accept(0, ok);
    #1 iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 o = obs(0);
    chk("midreset_in_ready", {31'd0, o[34]}, 32'd1);
    chk("midreset_out_valid", {31'd0, o[33]}, 32'd0);
    chk("midreset_busy", {31'd0, o[32]}, 32'd0);
    chk("midreset_out", o[31:0], 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    op(0, 16'd3, 16'd5, 1'b0, 0, res, lat);
    chk("after_reset_3x5", res, 32'd15);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] x, y;
      logic s;
      x = 16'($urandom_range(0, 255)); y = 16'($urandom_range(0, 255)); s = 1'($urandom);
      op(0, x, y, s, (i % 7 == 0) ? 3 : 0, res, lat);
    end
    stream(0, 20, 1'b0);
    stream(0, 20, 1'b1);

    foreach (c16[a]) foreach (c16[b]) for (int s = 0; s < 2; s++) begin
      op(1, c16[a], c16[b], 1'(s), 0, res, lat);
      chk("corner16", res, golden(c16[a], c16[b], 1'(s), 16));
    end
    op(1, 16'h8000, 16'h8000, 1'b1, 0, res, lat);
    chk("min16_sq", res, 32'h4000_0000);
    chk("lat16", 32'(lat), 32'd17);
    op(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, res, lat);
    chk("max16_sq", res, 32'hFFFE_0001);
    for (int i = 0; i < 200; i++) begin
      op(1, 16'($urandom), 16'($urandom), 1'($urandom), (i % 11 == 0) ? 2 : 0, res, lat);
    end
    stream(1, 10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
